// File: rtl/game_pkg.sv
// Shared types and default constants for the game-phase controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    // Fixed encodings: the renderer decodes these values directly.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        WIN       = 3'd4,
        LOSE      = 3'd5
    } game_state_t;

    localparam int GAME_TICKS_PER_SEC = 60;
    localparam int GAME_COUNTDOWN_SEC = 3;
    localparam int GAME_TIME_LIMIT    = 99;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for a debounced, already-synchronous button level.
// Latency: rise is combinational from btn against the previous-cycle level.
// Backpressure: none; one-cycle pulse per press.
//
// Ports: clk_game / reset_n (async, active-low), btn (level in), rise (pulse out).
// prev resets to 1 so a button held through reset release yields no edge.
module btn_edge_detect (
    input  logic clk_game,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b1;
        end else begin
            prev <= btn;
        end
    end

    assign rise = btn & ~prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-phase FSM (idle/countdown/play/pause/win/lose) driving the gameplay timer.
// Latency: inputs sampled at edge k are visible on the registered outputs after edge k.
// Backpressure: none; level inputs, buttons act on rising edges only.
//
// Ports: clk_game, reset_n (async active-low); start_btn, pause_btn, player_dead,
// level_done, seconds_count[7:0] in; timer_enable, timer_reset, phase[2:0],
// countdown_value[3:0], game_over, win out (all registered).
// Optional feature macro GAME_FLOW_PAUSE_EN: adds the PAUSED state and the pause
// edge detector; without it pause_btn is ignored.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = GAME_TICKS_PER_SEC,
    parameter int COUNTDOWN_SEC = GAME_COUNTDOWN_SEC,
    parameter int TIME_LIMIT    = GAME_TIME_LIMIT
) (
    input  logic       clk_game,
    input  logic       reset_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       player_dead,
    input  logic       level_done,
    input  logic [7:0] seconds_count,
    output logic       timer_enable,
    output logic       timer_reset,
    output logic [2:0] phase,
    output logic [3:0] countdown_value,
    output logic       game_over,
    output logic       win
);

    localparam logic [5:0] TICK_LAST = 6'(TICKS_PER_SEC - 1);
    localparam logic [3:0] CD_INIT   = 4'(COUNTDOWN_SEC);
    localparam logic [7:0] LIMIT     = 8'(TIME_LIMIT);

    game_state_t state_q, state_d;
    logic [5:0]  tick_q, tick_d;
    logic [3:0]  cd_d;
    logic        start_rise;
    logic        pause_rise;

    btn_edge_detect u_start_edge (
        .clk_game (clk_game),
        .reset_n  (reset_n),
        .btn      (start_btn),
        .rise     (start_rise)
    );

`ifdef GAME_FLOW_PAUSE_EN
    btn_edge_detect u_pause_edge (
        .clk_game (clk_game),
        .reset_n  (reset_n),
        .btn      (pause_btn),
        .rise     (pause_rise)
    );
`else
    // Port kept for a uniform interface; the level is deliberately ignored.
    logic unused_pause;
    assign unused_pause = pause_btn;
    assign pause_rise   = 1'b0;
`endif

    // Next-state / counter logic. countdown_value doubles as the seconds-left register.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        cd_d    = countdown_value;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = COUNTDOWN;
                    tick_d  = '0;
                    cd_d    = CD_INIT;
                end
            end
            COUNTDOWN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (countdown_value > 4'd1) begin
                        cd_d = countdown_value - 4'd1;
                    end else begin
                        state_d = PLAY;
                        cd_d    = '0;
                    end
                end else begin
                    tick_d = tick_q + 6'd1;
                end
            end
            PLAY: begin
                if (player_dead) begin
                    state_d = LOSE;
                end else if (level_done) begin
                    state_d = WIN;
                end else if (seconds_count >= LIMIT) begin
                    state_d = LOSE;
                end else if (pause_rise) begin
                    state_d = PAUSED;
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            PAUSED: begin
                if (pause_rise) begin
                    state_d = PLAY;
                end
            end
`endif
            WIN, LOSE: begin
                // Restart skips IDLE; the timer keeps its final count until timer_reset.
                if (start_rise) begin
                    state_d = COUNTDOWN;
                    tick_d  = '0;
                    cd_d    = CD_INIT;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                cd_d    = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it, so
    // they align with phase without a cycle of lag and never glitch.
    always_ff @(posedge clk_game or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            tick_q          <= '0;
            countdown_value <= '0;
            timer_enable    <= 1'b0;
            timer_reset     <= 1'b0;
            game_over       <= 1'b0;
            win             <= 1'b0;
        end else begin
            state_q         <= state_d;
            tick_q          <= tick_d;
            countdown_value <= cd_d;
            timer_enable    <= (state_d == PLAY);
            timer_reset     <= (state_d == COUNTDOWN) && (state_q != COUNTDOWN);
            game_over       <= (state_d == WIN) || (state_d == LOSE);
            win             <= (state_d == WIN);
        end
    end

    assign phase = state_q;

endmodule
